// File: rtl/router_pkg.sv
// Definitions shared by the router FSM and its datapath register stage:
// header field layout, the reserved address and the FSM state encoding.
package router_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  localparam int unsigned LEN_MSB = 7;
  localparam int unsigned LEN_LSB = 2;

  typedef enum logic [2:0] {
    StDecodeAddress,
    StLoadFirstData,
    StLoadData,
    StLoadParity,
    StFifoFullState,
    StLoadAfterFull,
    StWaitTillEmpty,
    StCheckParityError
  } fsm_state_e;

  function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input logic [LEN_MSB:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_reg.sv
// Router datapath register stage: registers bytes for the destination FIFO, parks one byte
// while the FIFO is full, and accumulates and checks the packet parity.
module router_reg
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
);

  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] header_q, header_d;
  logic [DATA_W-1:0] full_byte_q, full_byte_d;
  logic [DATA_W-1:0] int_parity_q, int_parity_d;
  logic [DATA_W-1:0] pkt_parity_q, pkt_parity_d;
  logic              parity_done_q, parity_done_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              err_q, err_d;

  always_comb begin
    dout_d          = dout_q;
    header_d        = header_q;
    full_byte_d     = full_byte_q;
    int_parity_d    = int_parity_q;
    pkt_parity_d    = pkt_parity_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;

    if (detect_add && pkt_valid && (data_in[ADDR_W-1:0] != ADDR_INVALID)) begin
      header_d = data_in;
    end

    if (lfd_state) begin
      dout_d = header_q;
    end else if (ld_state && !fifo_full) begin
      dout_d = data_in;
    end else if (ld_state && fifo_full) begin
      full_byte_d = data_in;
    end else if (laf_state) begin
      dout_d = full_byte_q;
    end

    // A byte parked while full is folded in from full_byte_q in LOAD_AFTER_FULL, not here.
    if (detect_add) begin
      int_parity_d = '0;
    end else if (lfd_state) begin
      int_parity_d = int_parity_q ^ header_q;
    end else if (ld_state && pkt_valid && !full_state && !fifo_full) begin
      int_parity_d = int_parity_q ^ data_in;
    end else if (laf_state && !low_pkt_valid_q) begin
      int_parity_d = int_parity_q ^ full_byte_q;
    end

    if (ld_state && !pkt_valid) begin
      pkt_parity_d = data_in;
    end else if (laf_state && low_pkt_valid_q) begin
      pkt_parity_d = full_byte_q;
    end

    if (ld_state && !pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end else if (rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end

    if ((ld_state && !fifo_full && !pkt_valid) ||
        (laf_state && low_pkt_valid_q && !parity_done_q)) begin
      parity_done_d = 1'b1;
    end else if (detect_add) begin
      parity_done_d = 1'b0;
    end

    if (rst_int_reg) begin
      err_d = (int_parity_q != pkt_parity_q);
    end else if (detect_add && pkt_valid) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q          <= '0;
      header_q        <= '0;
      full_byte_q     <= '0;
      int_parity_q    <= '0;
      pkt_parity_q    <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      header_q        <= header_d;
      full_byte_q     <= full_byte_d;
      int_parity_q    <= int_parity_d;
      pkt_parity_q    <= pkt_parity_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule
